// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: cache address/instruction, decode handshake and execute redirect.
// The master modport is the fetch sequencer; the slave modport is the cache/decode/execute side.
interface fetch_ctrl_if;
   logic [31:0] icache_addr;
   logic [31:0] icache_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output icache_addr,
      input  icache_instr,
      output out_valid,
      input  out_ready,
      output out_pc,
      output out_instr,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  icache_addr,
      output icache_instr,
      input  out_valid,
      output out_ready,
      input  out_pc,
      input  out_instr,
      output redirect_valid,
      output redirect_pc
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational cache and
// buffers up to two instructions for decode; execute redirects flush the queue.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   fetch_ctrl_if.master    bus,
   output logic [31:0]     fetch_count
);

   logic [31:0] pc;
   logic [1:0]  count;
   logic        rd_ptr;
   logic        wr_ptr;
   logic [31:0] entry_pc    [2];
   logic [31:0] entry_instr [2];
   logic        pop;
   logic        push;

   // out_valid comes from registered count only, so it never sees out_ready.
   assign bus.icache_addr = pc;
   assign bus.out_valid   = (count != 2'd0);
   assign bus.out_pc      = entry_pc[rd_ptr];
   assign bus.out_instr   = entry_instr[rd_ptr];

   assign pop  = bus.out_valid & bus.out_ready;
   assign push = enable & ~bus.redirect_valid & ((count < 2'd2) | pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc             <= RESET_PC;
         count          <= 2'd0;
         rd_ptr         <= 1'b0;
         wr_ptr         <= 1'b0;
         fetch_count    <= 32'd0;
         entry_pc[0]    <= 32'd0;
         entry_pc[1]    <= 32'd0;
         entry_instr[0] <= 32'd0;
         entry_instr[1] <= 32'd0;
      end else begin
         if (pop) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (bus.redirect_valid) begin
            // The head popped in this cycle is counted but its slot is discarded.
            count  <= 2'd0;
            rd_ptr <= wr_ptr;
            pc     <= {bus.redirect_pc[31:2], 2'b00};
         end else begin
            if (push) begin
               entry_pc[wr_ptr]    <= pc;
               entry_instr[wr_ptr] <= bus.icache_instr;
               wr_ptr              <= ~wr_ptr;
               pc                  <= pc + 32'(PC_STEP);
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
               count <= count + 2'd1;
            end else if (pop && !push) begin
               count <= count - 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a combinational cache model plus hand-computed
// expectations for streaming, stalls, redirects, halt/resume, reset and PC wrap.
module tb_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [31:0] fetch_count;
   int          n_vec;
   int          n_err;

   fetch_ctrl_if bus ();

   fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .bus         (bus.master),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] cache_word(input logic [31:0] a);
      case (a)
         32'h0: cache_word = 32'h02a0_0313;
         32'h4: cache_word = 32'h0063_83b3;
         32'h8: cache_word = 32'h3e80_0e13;
         32'hC: cache_word = 32'hffc3_cae3;
         default: cache_word = 32'h1300_0000 | {8'h00, a[23:0]};
      endcase
   endfunction

   always_comb bus.icache_instr = cache_word(bus.icache_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      enable = 1'b0;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;

      // Reset state
      step();
      chk("rst_addr",   bus.icache_addr, 32'h0);
      chk("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
      chk("rst_pc",     bus.out_pc, 32'h0);
      chk("rst_instr",  bus.out_instr, 32'h0);
      chk("rst_fcount", fetch_count, 32'd0);

      // Streaming: one instruction per cycle after a 1-cycle latency
      reset = 1'b0; enable = 1'b1; bus.out_ready = 1'b1;
      step();
      chk("s1_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("s1_pc",    bus.out_pc, 32'h0);
      chk("s1_instr", bus.out_instr, 32'h02a0_0313);
      chk("s1_addr",  bus.icache_addr, 32'h4);
      step();
      chk("s2_pc",    bus.out_pc, 32'h4);
      chk("s2_instr", bus.out_instr, 32'h0063_83b3);
      chk("s2_fc",    fetch_count, 32'd1);
      step();
      chk("s3_pc",    bus.out_pc, 32'h8);
      chk("s3_instr", bus.out_instr, 32'h3e80_0e13);
      step();
      chk("s4_pc",    bus.out_pc, 32'hC);
      chk("s4_instr", bus.out_instr, 32'hffc3_cae3);
      chk("s4_fc",    fetch_count, 32'd3);
      enable = 1'b0;
      step();
      chk("s5_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("s5_fc",    fetch_count, 32'd4);
      chk("s5_addr",  bus.icache_addr, 32'h10);

      // Backpressure from reset: two entries captured, address stalls at 8
      reset = 1'b1; enable = 1'b1; bus.out_ready = 1'b0;
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_pc",    bus.out_pc, 32'h0);
      chk("bp_addr",  bus.icache_addr, 32'h8);
      chk("bp_fc",    fetch_count, 32'd0);
      // Full queue, single ready cycle: push and pop together
      bus.out_ready = 1'b1;
      step();
      chk("fp_pc",   bus.out_pc, 32'h4);
      chk("fp_addr", bus.icache_addr, 32'hC);
      chk("fp_fc",   fetch_count, 32'd1);
      bus.out_ready = 1'b0;
      step();
      chk("full_hold_pc",   bus.out_pc, 32'h4);
      chk("full_hold_addr", bus.icache_addr, 32'hC);

      // Redirect while full, misaligned target, no pop that cycle
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0006;
      step();
      chk("rd1_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rd1_addr",  bus.icache_addr, 32'h4);
      chk("rd1_fc",    fetch_count, 32'd1);
      bus.redirect_valid = 1'b0;
      step();
      chk("rd1_tpc",   bus.out_pc, 32'h4);
      chk("rd1_tins",  bus.out_instr, 32'h0063_83b3);
      bus.out_ready = 1'b1;
      step();
      chk("rd1_next",  bus.out_pc, 32'h8);
      chk("rd1_fc2",   fetch_count, 32'd2);

      // Redirect with the head being consumed in the same cycle
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;
      step();
      chk("rd2_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rd2_fc",    fetch_count, 32'd3);
      chk("rd2_addr",  bus.icache_addr, 32'h100);
      bus.redirect_valid = 1'b0;
      step();
      chk("rd2_tpc",   bus.out_pc, 32'h100);
      chk("rd2_tins",  bus.out_instr, 32'h1300_0100);

      // Halt: queue drains, PC frozen, then resumes at held address
      enable = 1'b0;
      step();
      chk("halt_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("halt_fc",    fetch_count, 32'd4);
      chk("halt_addr",  bus.icache_addr, 32'h104);
      step();
      chk("halt_addr2", bus.icache_addr, 32'h104);
      chk("halt_fc2",   fetch_count, 32'd4);
      enable = 1'b1;
      step();
      chk("res_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("res_pc",    bus.out_pc, 32'h104);
      chk("res_addr",  bus.icache_addr, 32'h108);

      // Reset beats a pending redirect on a full queue
      bus.out_ready = 1'b0;
      step();
      chk("pre_rst_addr", bus.icache_addr, 32'h10C);
      reset = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
      bus.out_ready = 1'b1;
      step();
      chk("rr_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rr_addr",  bus.icache_addr, 32'h0);
      chk("rr_fc",    fetch_count, 32'd0);
      chk("rr_pc",    bus.out_pc, 32'h0);

      // PC wrap at the top of the address space
      reset = 1'b0; bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      chk("wr_addr", bus.icache_addr, 32'hFFFF_FFFC);
      bus.redirect_valid = 1'b0;
      step();
      chk("wr_pc",   bus.out_pc, 32'hFFFF_FFFC);
      chk("wr_ins",  bus.out_instr, 32'h13FF_FFFC);
      chk("wr_addr2", bus.icache_addr, 32'h0);
      step();
      chk("wr_next", bus.out_pc, 32'h0);
      chk("wr_fc",   fetch_count, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
